// File: rtl/dmem_hs_if.sv
// Request/response bus between an LSU (master) and the dmem_hs data memory (slave).
interface dmem_hs_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_hs.sv
// Word-organised data RAM with RISC-V byte/half/word access, valid/ready request and wait-state response.
// Optional: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_hs #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  dmem_hs_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Captured request
  logic              we_q, err_h_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [IDX_W-1:0]  idx_q;

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_lane;
  logic              req_err, f3_ok, oob, mis, is_half, is_word;
  logic              accept;
  logic [3:0]        be;
  logic [31:0]       wd;

  logic [IDX_W-1:0]  cur_idx;
  logic [1:0]        cur_lane;
  logic [2:0]        cur_f3;
  logic              cur_we, cur_err;
  logic [31:0]       rd_word, load_val;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign addr    = bus.req_addr;
  assign req_idx = addr[IDX_W+1:2];
  assign accept  = (state_q == S_IDLE) && ready_q && bus.req_valid;

  // Request decode: range, legality, alignment and store byte enables
  always_comb begin
    is_half = (bus.req_funct3[1:0] == 2'b01);
    is_word = (bus.req_funct3[1:0] == 2'b10);
    oob     = ((addr >> (IDX_W + 2)) != '0);
    unique case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_we;
      default:                f3_ok = 1'b0;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    req_lane = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
    req_err  = oob || !f3_ok || mis;
    be = 4'b0000;
    wd = bus.req_wdata;
    unique case (bus.req_funct3[1:0])
      2'b00:   begin be = 4'b0001 << req_lane; wd = {4{bus.req_wdata[7:0]}}; end
      2'b01:   begin be = req_lane[1] ? 4'b1100 : 4'b0011; wd = {2{bus.req_wdata[15:0]}}; end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stores commit at the acceptance edge; the array itself is never reset
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[req_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // With zero wait states the load samples the live request, otherwise the held copy
  always_comb begin
    cur_idx  = (state_q == S_IDLE) ? req_idx       : idx_q;
    cur_lane = (state_q == S_IDLE) ? req_lane      : lane_q;
    cur_f3   = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;
    cur_we   = (state_q == S_IDLE) ? bus.req_we    : we_q;
    cur_err  = (state_q == S_IDLE) ? req_err       : err_h_q;
    rd_word  = mem[cur_idx];
    byte_v   = 8'(rd_word >> {cur_lane, 3'b000});
    half_v   = cur_lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (cur_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'h0, half_v};
      3'b010:  load_val = rd_word;
      default: load_val = 32'h0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
    err_d   = (state_d == S_RESP) && cur_err;
    rdata_d = ((state_d == S_RESP) && !cur_err && !cur_we) ? load_val : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      err_h_q <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_h_q <= req_err;
        f3_q    <= bus.req_funct3;
        lane_q  <= req_lane;
        idx_q   <= req_idx;
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs: two instances (2 and 3 wait states), directed accesses, reset abort.
module tb_dmem_hs;
  localparam int unsigned WS_A = 2;
  localparam int unsigned WS_B = 3;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  dmem_hs_if #(.ADDR_W(32)) a_if ();
  dmem_hs_if #(.ADDR_W(32)) b_if ();

  dmem_hs #(.DEPTH(1024), .WAIT_STATES(WS_A), .ADDR_W(32)) u_a (.clk(clk), .rst_n(rst_a), .bus(a_if.slave));
  dmem_hs #(.DEPTH(1024), .WAIT_STATES(WS_B), .ADDR_W(32)) u_b (.clk(clk), .rst_n(rst_b), .bus(b_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      a_if.req_valid = v; a_if.req_we = we; a_if.req_funct3 = f3;
      a_if.req_addr = addr; a_if.req_wdata = wdata;
    end else begin
      b_if.req_valid = v; b_if.req_we = we; b_if.req_funct3 = f3;
      b_if.req_addr = addr; b_if.req_wdata = wdata;
    end
  endtask

  // Waits (bounded) at negedges until the selected DUT shows req_ready
  task automatic wait_ready(input int d, input string name);
    int n = 0;
    while (((d == 0) ? a_if.req_ready : b_if.req_ready) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; fails++;
      $display("FAIL %s: req_ready timeout got 0 expected 1", name);
    end
  endtask

  // Issue one request; expected response is queued with its due cycle
  task automatic issue(input int d, input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit expect_resp);
    exp_t x;
    wait_ready(d, name);
    drive(d, 1'b1, we, f3, addr, wdata);
    x.name  = name;
    x.rdata = exp_rdata;
    x.err   = exp_err;
    x.cyc   = cyc + 1 + int'((d == 0) ? WS_A : WS_B);
    if (expect_resp) begin
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] rd, input logic e, input logic rdy);
    exp_t x;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (v === 1'b1) begin
      if (sz == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", d);
      end else begin
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        check({x.name, " rdata"}, rd, x.rdata);
        check({x.name, " err"}, 32'(e), 32'(x.err));
        check({x.name, " cycle"}, 32'(cyc), 32'(x.cyc));
        check({x.name, " ready_in_resp"}, 32'(rdy), 32'h0);
      end
    end else if (sz > 0) begin
      check("ready_while_busy", 32'(rdy), 32'h0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, a_if.resp_valid, a_if.resp_rdata, a_if.resp_err, a_if.req_ready);
    mon(1, b_if.resp_valid, b_if.resp_rdata, b_if.resp_err, b_if.req_ready);
  end

  initial begin
    logic [31:0] mis_rdata;
    logic        mis_err;
    int          n;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_rdata = 32'h0;        mis_err = 1'b1;
`else
    mis_rdata = 32'h8001AA44; mis_err = 1'b0;
`endif
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("reset a ready", 32'(a_if.req_ready), 32'h0);
    check("reset a valid", 32'(a_if.resp_valid), 32'h0);
    check("reset a rdata", a_if.resp_rdata, 32'h0);
    check("reset a err", 32'(a_if.resp_err), 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    issue(0, "sw_10",   1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
    issue(0, "lw_10",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    issue(0, "sw_20",   1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0,        1'b0, 1'b1);
    issue(0, "sb_21",   1'b1, 3'b000, 32'h21,   32'h000000AA, 32'h0,        1'b0, 1'b1);
    issue(0, "lw_20a",  1'b0, 3'b010, 32'h20,   32'h0,        32'h1122AA44, 1'b0, 1'b1);
    issue(0, "lb_21",   1'b0, 3'b000, 32'h21,   32'h0,        32'hFFFFFFAA, 1'b0, 1'b1);
    issue(0, "lbu_21",  1'b0, 3'b100, 32'h21,   32'h0,        32'h000000AA, 1'b0, 1'b1);
    issue(0, "sh_22",   1'b1, 3'b001, 32'h22,   32'h00008001, 32'h0,        1'b0, 1'b1);
    issue(0, "lh_22",   1'b0, 3'b001, 32'h22,   32'h0,        32'hFFFF8001, 1'b0, 1'b1);
    issue(0, "lhu_22",  1'b0, 3'b101, 32'h22,   32'h0,        32'h00008001, 1'b0, 1'b1);
    issue(0, "lw_20b",  1'b0, 3'b010, 32'h20,   32'h0,        32'h8001AA44, 1'b0, 1'b1);
    issue(0, "lb_23",   1'b0, 3'b000, 32'h23,   32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
    issue(0, "lhu_20",  1'b0, 3'b101, 32'h20,   32'h0,        32'h0000AA44, 1'b0, 1'b1);
    issue(0, "lw_oob",  1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 1'b1);
    issue(0, "ld_f011", 1'b0, 3'b011, 32'h20,   32'h0,        32'h0,        1'b1, 1'b1);
    issue(0, "ld_f110", 1'b0, 3'b110, 32'h20,   32'h0,        32'h0,        1'b1, 1'b1);
    issue(0, "sb_f100", 1'b1, 3'b100, 32'h20,   32'h00000077, 32'h0,        1'b1, 1'b1);
    issue(0, "sw_oob",  1'b1, 3'b010, 32'h1020, 32'h12345678, 32'h0,        1'b1, 1'b1);
    issue(0, "lw_20c",  1'b0, 3'b010, 32'h20,   32'h0,        32'h8001AA44, 1'b0, 1'b1);
    issue(0, "lw_22",   1'b0, 3'b010, 32'h22,   32'h0,        mis_rdata,    mis_err, 1'b1);

    // Reset one cycle after a store is accepted: no response, store survives
    issue(1, "sw_30_abort", 1'b1, 3'b010, 32'h30, 32'h00000055, 32'h0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check("abort ready", 32'(b_if.req_ready), 32'h0);
    check("abort valid", 32'(b_if.resp_valid), 32'h0);
    check("abort rdata", b_if.resp_rdata, 32'h0);
    check("abort err", 32'(b_if.resp_err), 32'h0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    issue(1, "lw_30_b", 1'b0, 3'b010, 32'h30, 32'h0, 32'h00000055, 1'b0, 1'b1);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL drain: %0d responses outstanding expected 0", q0.size() + q1.size());
    end
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
